sdram_arb: RTL and testbench

//   Round-robin arbiter sharing the single SDRAM read/write port between NREQ requesters
//   (CPU ROM/RAM bridge, video/DMA fetch, etc.) in the clk_cpu domain.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_arb_pick.sv | 44 ++++
 rtl/sdram_arb.sv | 101 ++++++++++
 tb/tb_sdram_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 25;
   localparam int GW       = $clog2(NREQ_DEF);

endpackage

// File: rtl/sdram_arb_pick.sv
// Requester selection: round-robin from last_grant+1, or fixed lowest-index when
// SDRAM_ARB_FIXED_PRIO_EN is defined. Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module sdram_arb_pick
   import sdram_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   last_grant,
   output logic            any,
   output logic [IW-1:0]   idx
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = ^last_grant;

   // Lowest asserted index wins; scan downward so the smallest index is written last.
   always_comb begin
      any = |valid;
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (valid[i]) idx = IW'(i);
      end
   end
`else
   logic [IW-1:0] cand;

   // Search last_grant+1, +2, ... mod NREQ; scan from the farthest distance so the
   // nearest asserted candidate is written last and wins.
   always_comb begin
      any  = |valid;
      idx  = '0;
      cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IW'((int'(last_grant) + k) % NREQ);
         if (valid[cand]) idx = cand;
      end
   end
`endif

endmodule

// File: rtl/sdram_arb.sv
// Shares one SDRAM rd/we port among NREQ requesters, one transaction outstanding
// (SDRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin).
// Latency: ack 3 cycles min after req seen in IDLE; 4-cycle min spacing. Backpressure: req held until ack; waits on rdy forever.
module sdram_arb
   import sdram_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic                 clk_cpu,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*32-1:0]   req_wdata,
   input  logic [NREQ*4-1:0]    req_be,
   output logic [NREQ-1:0]      req_ack,
   output logic [31:0]          rdata,
   output logic [IW-1:0]        grant_idx,
   output logic                 busy,
   output logic [AW-1:0]        mem_addr,
   output logic [31:0]          mem_din,
   output logic [3:0]           mem_be,
   output logic                 mem_rd,
   output logic                 mem_we,
   input  logic                 mem_rd_rdy,
   input  logic                 mem_we_rdy,
   input  logic [31:0]          mem_dout
);

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] last_grant;
   logic          we_lat;
   logic          pick_any;
   logic [IW-1:0] pick_idx;

   sdram_arb_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .valid      (req_valid),
      .last_grant (last_grant),
      .any        (pick_any),
      .idx        (pick_idx)
   );

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk_cpu) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state plus strobes/ack decoded from the registered state.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      mem_rd    = 1'b0;
      mem_we    = 1'b0;
      req_ack   = '0;
      case (state)
         IDLE:  if (pick_any) state_nxt = ISSUE;
         ISSUE: begin
            mem_rd    = ~we_lat;
            mem_we    = we_lat;
            state_nxt = WAIT;
         end
         WAIT:  if (we_lat ? mem_we_rdy : mem_rd_rdy) state_nxt = DONE;
         DONE: begin
            req_ack[grant_idx] = 1'b1;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Payload latch on grant, read-data capture, and round-robin pointer update.
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         grant_idx  <= '0;
         last_grant <= IW'(NREQ - 1);
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_be     <= '0;
         we_lat     <= 1'b0;
         rdata      <= '0;
      end else begin
         if (state == IDLE && pick_any) begin
            grant_idx <= pick_idx;
            we_lat    <= req_we[pick_idx];
            mem_addr  <= req_addr[int'(pick_idx)*AW +: AW];
            mem_din   <= req_wdata[int'(pick_idx)*32 +: 32];
            mem_be    <= req_be[int'(pick_idx)*4 +: 4];
         end
         if (state == WAIT && !we_lat && mem_rd_rdy) rdata <= mem_dout;
         if (state == DONE) last_grant <= grant_idx;
      end
   end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb with a transaction-level reference model.
// Latency: n/a. Backpressure: requesters hold req_valid until ack.
module tb_sdram_arb;

   localparam int NREQ = 3;
   localparam int AW   = 25;
   localparam int IW   = $clog2(NREQ);

   logic                clk_cpu = 1'b0;
   logic                reset   = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_we    = '0;
   logic [NREQ*AW-1:0]  req_addr  = '0;
   logic [NREQ*32-1:0]  req_wdata = '0;
   logic [NREQ*4-1:0]   req_be    = '0;
   logic [NREQ-1:0]     req_ack;
   logic [31:0]         rdata;
   logic [IW-1:0]       grant_idx;
   logic                busy;
   logic [AW-1:0]       mem_addr;
   logic [31:0]         mem_din;
   logic [3:0]          mem_be;
   logic                mem_rd;
   logic                mem_we;
   logic                mem_rd_rdy = 1'b0;
   logic                mem_we_rdy = 1'b0;
   logic [31:0]         mem_dout   = '0;

   sdram_arb #(.NREQ(NREQ), .AW(AW)) dut (
      .clk_cpu(clk_cpu), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be), .req_ack(req_ack),
      .rdata(rdata), .grant_idx(grant_idx), .busy(busy),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
      .mem_rd(mem_rd), .mem_we(mem_we),
      .mem_rd_rdy(mem_rd_rdy), .mem_we_rdy(mem_we_rdy), .mem_dout(mem_dout)
   );

   always #5 clk_cpu = ~clk_cpu;

   int cyc = 0;
   always @(posedge clk_cpu) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- stimulus configuration ----------------
   int          pend    [NREQ];
   logic        cfg_we  [NREQ];
   logic [AW-1:0] cfg_addr [NREQ];
   logic [31:0] cfg_wdata [NREQ];
   logic [3:0]  cfg_be  [NREQ];
   int          rsp_delay  = 2;
   logic [31:0] rsp_data   = '0;
   logic        spur       = 1'b0;
   logic        idle_pulse = 1'b0;

   // ---------------- observation logs ----------------
   int          rd_cyc[$];
   logic [AW-1:0] rd_addr[$];
   int          we_cyc[$];
   logic [31:0] we_din[$];
   logic [3:0]  we_be[$];
   int          ack_idx[$];
   logic [31:0] ack_rd[$];
   int          ack_cyc[$];
   int          last_werdy = -1;

   // ---------------- reference model ----------------
   // Transaction view: a grant opens a transaction; age counts cycles since the
   // strobe cycle; the first matching rdy at age>=1 completes it; the ack cycle follows.
   logic        m_busy, m_fin, m_we;
   int          m_age, m_grant, m_last;
   logic [AW-1:0] m_addr;
   logic [31:0] m_din, m_rdata;
   logic [3:0]  m_be;

   task automatic model_clear();
      m_busy = 0; m_fin = 0; m_we = 0; m_age = 0; m_grant = 0; m_last = NREQ - 1;
      m_addr = '0; m_din = '0; m_be = '0; m_rdata = '0;
   endtask

   function automatic int choose(input logic [NREQ-1:0] v, input int last);
      int best  = 0;
      int bestd = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         int d;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
         d = i;
`else
         d = (i + 2 * NREQ - last - 1) % NREQ;
`endif
         if (v[i] && d < bestd) begin bestd = d; best = i; end
      end
      return best;
   endfunction

   initial begin
      model_clear();
      forever begin
         @(posedge clk_cpu);
         if (reset) model_clear();
         else if (!m_busy) begin
            if (req_valid != '0) begin
               m_grant = choose(req_valid, m_last);
               m_we    = req_we[m_grant];
               m_addr  = req_addr[m_grant*AW +: AW];
               m_din   = req_wdata[m_grant*32 +: 32];
               m_be    = req_be[m_grant*4 +: 4];
               m_busy  = 1; m_age = 0; m_fin = 0;
            end
         end else if (m_fin) begin
            m_last = m_grant; m_busy = 0; m_fin = 0;
         end else begin
            if (m_age >= 1 && (m_we ? mem_we_rdy : mem_rd_rdy)) begin
               if (!m_we) m_rdata = mem_dout;
               m_fin = 1;
            end
            m_age++;
         end
      end
   end

   task automatic wait_acks(input int n, input int budget);
      int k = 0;
      while (ack_idx.size() < n && k < budget) begin @(posedge clk_cpu); k++; end
      chk("acks_seen", 64'(ack_idx.size()), 64'(n));
   endtask

   task automatic settle();
      repeat (3) @(posedge clk_cpu);
      #1;
   endtask

   int exp_order[6];
   int n0, r0, w0, k;

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0; cfg_we[i] = 0; cfg_addr[i] = '0; cfg_wdata[i] = '0; cfg_be[i] = '0;
      end
      fork
         // compare + monitor, every negedge once reset has been applied
         forever begin
            logic [NREQ-1:0] exp_ack;
            @(negedge clk_cpu);
            if (cyc > 0) begin
               exp_ack = '0;
               if (m_busy && m_fin) exp_ack[m_grant] = 1'b1;
               chk("busy",      64'(busy),      64'(m_busy));
               chk("grant_idx", 64'(grant_idx), 64'(m_grant));
               chk("req_ack",   64'(req_ack),   64'(exp_ack));
               chk("mem_rd",    64'(mem_rd),    64'(m_busy && !m_fin && m_age == 0 && !m_we));
               chk("mem_we",    64'(mem_we),    64'(m_busy && !m_fin && m_age == 0 && m_we));
               chk("mem_addr",  64'(mem_addr),  64'(m_addr));
               chk("mem_din",   64'(mem_din),   64'(m_din));
               chk("mem_be",    64'(mem_be),    64'(m_be));
               chk("rdata",     64'(rdata),     64'(m_rdata));
               if (mem_rd) begin rd_cyc.push_back(cyc); rd_addr.push_back(mem_addr); end
               if (mem_we) begin we_cyc.push_back(cyc); we_din.push_back(mem_din); we_be.push_back(mem_be); end
               if (mem_we_rdy) last_werdy = cyc;
               for (int i = 0; i < NREQ; i++) begin
                  if (req_ack[i]) begin
                     ack_idx.push_back(i); ack_rd.push_back(rdata); ack_cyc.push_back(cyc);
                  end
               end
            end
         end
         // requester engine: assert in the cycle after posedge, drop during the ack cycle
         forever begin
            @(posedge clk_cpu); #1;
            for (int i = 0; i < NREQ; i++) begin
               if (!req_valid[i] && pend[i] > 0) begin
                  req_valid[i] = 1'b1;
                  req_we[i]    = cfg_we[i];
                  req_addr[i*AW +: AW]  = cfg_addr[i];
                  req_wdata[i*32 +: 32] = cfg_wdata[i];
                  req_be[i*4 +: 4]      = cfg_be[i];
               end
            end
            @(negedge clk_cpu);
            for (int i = 0; i < NREQ; i++) begin
               if (req_ack[i] && req_valid[i]) begin
                  req_valid[i] = 1'b0;
                  pend[i]--;
                  req_we[i]    = 1'($urandom);
                  req_addr[i*AW +: AW]  = AW'($urandom);
                  req_wdata[i*32 +: 32] = $urandom;
                  req_be[i*4 +: 4]      = 4'($urandom);
               end
            end
         end
         // SDRAM responder
         forever begin
            logic kind;
            @(negedge clk_cpu);
            if (idle_pulse) begin
               mem_rd_rdy = 1'b1; mem_we_rdy = 1'b1; mem_dout = 32'hBAD0BAD0;
               @(negedge clk_cpu);
               mem_rd_rdy = 1'b0; mem_we_rdy = 1'b0; mem_dout = '0; idle_pulse = 1'b0;
            end else if (mem_rd || mem_we) begin
               kind = mem_we;
               if (spur) begin mem_rd_rdy = 1'b1; mem_we_rdy = 1'b1; mem_dout = 32'hBAD0BAD0; end
               for (int d = 0; d < rsp_delay; d++) begin
                  @(posedge clk_cpu); #1;
                  mem_rd_rdy = 1'b0; mem_we_rdy = 1'b0;
                  if (spur && d < rsp_delay - 1) begin
                     if (kind) mem_rd_rdy = 1'b1; else mem_we_rdy = 1'b1;
                  end
               end
               if (kind) mem_we_rdy = 1'b1;
               else begin mem_rd_rdy = 1'b1; mem_dout = rsp_data; end
               @(posedge clk_cpu); #1;
               mem_rd_rdy = 1'b0; mem_we_rdy = 1'b0; mem_dout = '0;
            end
         end
      join_none

      // ---- reset state ----
      repeat (3) @(posedge clk_cpu);
      #1 reset = 1'b0;
      @(negedge clk_cpu);
      chk("rst_busy",    64'(busy),      64'd0);
      chk("rst_ack",     64'(req_ack),   64'd0);
      chk("rst_grant",   64'(grant_idx), 64'd0);
      chk("rst_addr",    64'(mem_addr),  64'd0);
      chk("rst_rdata",   64'(rdata),     64'd0);
      settle();

      // ---- fairness: all three requesting continuously ----
      n0 = ack_idx.size();
      rsp_delay = 1; rsp_data = 32'h11110000;
      for (int i = 0; i < NREQ; i++) begin cfg_we[i] = 0; cfg_addr[i] = AW'(32'h10 * (i + 1)); end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0, 0};
      pend[0] = 6; pend[1] = 1; pend[2] = 1;
      wait_acks(n0 + 8, 400);
`else
      exp_order = '{0, 1, 2, 0, 1, 2};
      pend[0] = 2; pend[1] = 2; pend[2] = 2;
      wait_acks(n0 + 6, 400);
`endif
      for (int i = 0; i < 6; i++) chk($sformatf("order%0d", i), 64'(ack_idx[n0 + i]), 64'(exp_order[i]));
      settle();

      // ---- read from requester 0, rdy two cycles after the strobe ----
      n0 = ack_idx.size(); r0 = rd_cyc.size(); w0 = we_cyc.size();
      rsp_delay = 2; rsp_data = 32'hDEADBEEF;
      cfg_we[0] = 0; cfg_addr[0] = 25'h000100; pend[0] = 1;
      wait_acks(n0 + 1, 100);
      chk("rd_ack_idx",   64'(ack_idx[n0]),         64'd0);
      chk("rd_ack_data",  64'(ack_rd[n0]),          64'hDEADBEEF);
      chk("rd_strobes",   64'(rd_cyc.size() - r0),  64'd1);
      chk("rd_addr",      64'(rd_addr[r0]),         64'h000100);
      chk("rd_no_we",     64'(we_cyc.size() - w0),  64'd0);
      chk("rd_latency",   64'(ack_cyc[n0] - rd_cyc[r0]), 64'd3);
      settle();

      // ---- write from requester 1 ----
      n0 = ack_idx.size(); r0 = rd_cyc.size(); w0 = we_cyc.size();
      cfg_we[1] = 1; cfg_addr[1] = 25'h000200; cfg_wdata[1] = 32'h12345678; cfg_be[1] = 4'b0011;
      pend[1] = 1;
      wait_acks(n0 + 1, 100);
      chk("wr_ack_idx",   64'(ack_idx[n0]),         64'd1);
      chk("wr_strobes",   64'(we_cyc.size() - w0),  64'd1);
      chk("wr_din",       64'(we_din[w0]),          64'h12345678);
      chk("wr_be",        64'(we_be[w0]),           64'h3);
      chk("wr_no_rd",     64'(rd_cyc.size() - r0),  64'd0);
      chk("wr_ack_after", 64'(ack_cyc[n0] - last_werdy), 64'd1);
      chk("wr_rdata_hold", 64'(rdata),              64'hDEADBEEF);
      cfg_we[1] = 0;
      settle();

      // ---- spurious rdy in IDLE, then in ISSUE and wrong-type rdy in WAIT ----
      n0 = ack_idx.size();
      idle_pulse = 1'b1;
      repeat (4) @(posedge clk_cpu);
      #1;
      chk("idle_rdy_no_ack", 64'(ack_idx.size()), 64'(n0));
      chk("idle_rdy_rdata",  64'(rdata),          64'hDEADBEEF);
      r0 = rd_cyc.size();
      spur = 1'b1; rsp_delay = 2; rsp_data = 32'hCAFEF00D;
      cfg_we[0] = 0; cfg_addr[0] = 25'h000300; pend[0] = 1;
      wait_acks(n0 + 1, 100);
      spur = 1'b0;
      chk("spur_ack_data", 64'(ack_rd[n0]),                64'hCAFEF00D);
      chk("spur_latency",  64'(ack_cyc[n0] - rd_cyc[r0]),  64'd3);
      settle();

      // ---- reset while waiting for rdy ----
      n0 = ack_idx.size(); r0 = rd_cyc.size();
      rsp_delay = 2; rsp_data = 32'h55AA55AA;
      cfg_we[0] = 0; cfg_addr[0] = 25'h000400; pend[0] = 1;
      k = 0;
      while (rd_cyc.size() == r0 && k < 50) begin @(posedge clk_cpu); k++; end
      chk("rst_strobe_seen", 64'(rd_cyc.size() - r0), 64'd1);
      #1 reset = 1'b1;
      @(posedge clk_cpu);
      #1 reset = 1'b0;
      @(negedge clk_cpu);
      chk("midrst_busy",  64'(busy),     64'd0);
      chk("midrst_addr",  64'(mem_addr), 64'd0);
      chk("midrst_rdata", 64'(rdata),    64'd0);
      chk("midrst_ack",   64'(req_ack),  64'd0);
      chk("midrst_noack", 64'(ack_idx.size()), 64'(n0));
      wait_acks(n0 + 1, 100);
      chk("postrst_idx",   64'(ack_idx[n0]),        64'd0);
      chk("postrst_data",  64'(ack_rd[n0]),         64'h55AA55AA);
      chk("postrst_strb",  64'(rd_cyc.size() - r0), 64'd2);
      chk("postrst_addr",  64'(rd_addr[r0 + 1]),    64'h000400);
      settle();

      // ---- back-to-back reads from requester 2, rdy on first WAIT cycle ----
      n0 = ack_idx.size(); r0 = rd_cyc.size();
      rsp_delay = 1; rsp_data = 32'h0F0F0F0F;
      cfg_we[2] = 0; cfg_addr[2] = 25'h000500; pend[2] = 2;
      wait_acks(n0 + 2, 100);
      chk("b2b_idx0",    64'(ack_idx[n0]),     64'd2);
      chk("b2b_idx1",    64'(ack_idx[n0 + 1]), 64'd2);
      chk("b2b_spacing", 64'(rd_cyc[r0 + 1] - rd_cyc[r0]), 64'd4);
      chk("b2b_latency", 64'(ack_cyc[n0] - rd_cyc[r0]),     64'd2);
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
